// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute over a shared datapath.
// Optional retired-instruction counter is built only when PERF_COUNTER_EN is defined.
module multicycle_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic        reg_write_o,
  output logic [1:0]  alu_a_sel_o,
  output logic [1:0]  alu_b_sel_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  wb_sel_o,
  output logic        illegal_o,
  output logic [3:0]  state_o,
  output logic [31:0] instret_o
);

  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_ALU_WB    = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_READ  = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WRITE = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_JALR      = 4'd12,
    S_LUI       = 4'd13,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;

  state_t state_reg, state_next;

  // Only funct3[0] matters here (beq/bne polarity); the rest is decoded by the ALU control.
  logic unused_funct3;
  assign unused_funct3 = ^funct3_i[2:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_START;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    pc_src_o    = 1'b0;
    reg_write_o = 1'b0;
    alu_a_sel_o = 2'd0;
    alu_b_sel_o = 2'd0;
    alu_op_o    = 2'd0;
    wb_sel_o    = 2'd0;
    illegal_o   = 1'b0;
    case (state_reg)
      S_START: state_next = S_FETCH;
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_b_sel_o = 2'd2;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut while dispatching.
        alu_a_sel_o = 2'd2;
        alu_b_sel_o = 2'd1;
        case (opcode_i)
          OP_R:               state_next = S_EXEC_R;
          OP_I:               state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
          OP_BRANCH:          state_next = S_BRANCH;
          OP_JAL:             state_next = S_JAL;
          OP_JALR:            state_next = S_JALR;
          OP_LUI:             state_next = S_LUI;
          default:            state_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_a_sel_o = 2'd1;
        alu_op_o    = 2'd2;
        state_next  = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_a_sel_o = 2'd1;
        alu_b_sel_o = 2'd1;
        alu_op_o    = 2'd2;
        state_next  = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_o = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_a_sel_o = 2'd1;
        alu_b_sel_o = 2'd1;
        state_next  = (opcode_i == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_o = 1'b1;
        wb_sel_o    = 2'd1;
        state_next  = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_ready_i) state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_a_sel_o = 2'd1;
        alu_op_o    = 2'd1;
        pc_src_o    = 1'b1;
        pc_write_o  = zero_i ^ funct3_i[0];
        state_next  = S_FETCH;
      end
      S_JAL: begin
        pc_write_o  = 1'b1;
        pc_src_o    = 1'b1;
        reg_write_o = 1'b1;
        wb_sel_o    = 2'd2;
        state_next  = S_FETCH;
      end
      S_JALR: begin
        alu_a_sel_o = 2'd1;
        alu_b_sel_o = 2'd1;
        pc_write_o  = 1'b1;
        reg_write_o = 1'b1;
        wb_sel_o    = 2'd2;
        state_next  = S_FETCH;
      end
      S_LUI: begin
        reg_write_o = 1'b1;
        wb_sel_o    = 2'd3;
        state_next  = S_FETCH;
      end
      S_TRAP: illegal_o = 1'b1;
      // Unused encoding 14: recover through START rather than lock up.
      default: state_next = S_START;
    endcase
  end

  assign state_o = state_reg;

`ifdef PERF_COUNTER_EN
  // Every path back to FETCH, other than leaving START, is an instruction's final cycle.
  logic        retire;
  logic [31:0] instret_reg;
  assign retire = (state_next == S_FETCH) && (state_reg != S_FETCH) && (state_reg != S_START);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instret_reg <= 32'd0;
    else if (retire) instret_reg <= instret_reg + 32'd1;
  end
  assign instret_o = instret_reg;
`else
  assign instret_o = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus random instruction
// streams checked against a per-instruction-class model (latency, pulse counts, selects).
module tb_multicycle_control_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic        zero_i;
  logic        mem_ready_i;
  logic        mem_req_o, mem_we_o, ir_write_o, pc_write_o, pc_src_o, reg_write_o, illegal_o;
  logic [1:0]  alu_a_sel_o, alu_b_sel_o, alu_op_o, wb_sel_o;
  logic [3:0]  state_o;
  logic [31:0] instret_o;
  logic [14:0] ctrl;

  int tests_run = 0;
  int tests_failed = 0;
  int unsigned exp_instret = 0;

`ifdef PERF_COUNTER_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  multicycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .funct3_i(funct3_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
    .reg_write_o(reg_write_o), .alu_a_sel_o(alu_a_sel_o), .alu_b_sel_o(alu_b_sel_o),
    .alu_op_o(alu_op_o), .wb_sel_o(wb_sel_o), .illegal_o(illegal_o), .state_o(state_o),
    .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  // illegal_o is the lowest bit so "everything but illegal" is ctrl >> 1.
  assign ctrl = {mem_req_o, mem_we_o, ir_write_o, pc_write_o, pc_src_o, reg_write_o,
                 alu_a_sel_o, alu_b_sel_o, alu_op_o, wb_sel_o, illegal_o};

  function automatic logic [31:0] instret_model();
    return PERF ? 32'(exp_instret) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT at the start of a FETCH cycle with a fresh counter.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_instret = 0;
    tick();
  endtask

  // Runs one instruction starting in FETCH; fw = fetch wait cycles, mw = data wait cycles.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input int fw, input int mw);
    bit ld, st, mem, br, jal, jalr, lui;
    int base, len, n_ir, n_pcw, n_rw, n_we, n_fetch, req_err, exp_pcw, exp_rw;
    logic [3:0] first_state;
    logic [1:0] wb_seen, exp_wb;
    logic       src_seen, exp_src;
    ld = (op == 7'h03); st = (op == 7'h23); mem = ld || st;
    br = (op == 7'h63); jal = (op == 7'h6F); jalr = (op == 7'h67); lui = (op == 7'h37);
    base = ld ? 5 : ((br || jal || jalr || lui) ? 3 : 4);
    len = base + fw + (mem ? mw : 0);
    exp_rw = (st || br) ? 0 : 1;
    exp_pcw = 1 + ((jal || jalr) ? 1 : 0) + ((br && (z ^ f3[0])) ? 1 : 0);
    exp_wb = ld ? 2'd1 : ((jal || jalr) ? 2'd2 : (lui ? 2'd3 : 2'd0));
    exp_src = jalr ? 1'b0 : 1'b1;
    n_ir = 0; n_pcw = 0; n_rw = 0; n_we = 0; n_fetch = 0; req_err = 0;
    wb_seen = 2'bxx; src_seen = 1'bx; first_state = 4'hx;
    opcode_i = op; funct3_i = f3; zero_i = z;
    for (int c = 0; c < len; c++) begin
      bit req_exp;
      req_exp = (c <= fw) || (mem && c >= fw + 3 && c <= fw + 3 + mw);
      if (req_exp) mem_ready_i = (c == fw) || (mem && c == fw + 3 + mw);
      else         mem_ready_i = 1'($urandom_range(0, 1));
      #1;
      if (c == 0) first_state = state_o;
      if (state_o === 4'd1) n_fetch++;
      if (mem_req_o !== req_exp) req_err++;
      if (ir_write_o === 1'b1) n_ir++;
      if (pc_write_o === 1'b1) begin
        n_pcw++;
        if (c > fw) src_seen = pc_src_o;
      end
      if (reg_write_o === 1'b1) begin n_rw++; wb_seen = wb_sel_o; end
      if (mem_we_o === 1'b1) n_we++;
      tick();
    end
    if (exp_rw == 1) exp_instret++;
    else exp_instret++;
    $display("[TB] instr op=%02h f3=%0d z=%0b fw=%0d mw=%0d cycles=%0d", op, f3, z, fw, mw, len);
    tests_run++;
    if (first_state !== 4'd1 || state_o !== 4'd1 || n_fetch != fw + 1) begin
      tests_failed++;
      $display("FAIL latency op=%02h: start=%0d end=%0d fetch_cycles=%0d, required 1/1/%0d over %0d cycles",
               op, first_state, state_o, n_fetch, fw + 1, len);
    end
    tests_run++;
    if (req_err != 0 || n_ir != 1) begin
      tests_failed++;
      $display("FAIL mem_req/ir_write op=%02h: req_errors=%0d ir_pulses=%0d, required 0/1", op, req_err, n_ir);
    end
    tests_run++;
    if (n_pcw != exp_pcw || n_rw != exp_rw || n_we != (st ? mw + 1 : 0)) begin
      tests_failed++;
      $display("FAIL pulses op=%02h: pc_write=%0d reg_write=%0d mem_we=%0d, required %0d/%0d/%0d",
               op, n_pcw, n_rw, n_we, exp_pcw, exp_rw, st ? mw + 1 : 0);
    end
    if (exp_rw == 1) begin
      tests_run++;
      if (wb_seen !== exp_wb) begin
        tests_failed++;
        $display("FAIL wb_sel op=%02h: got %0d, required %0d", op, wb_seen, exp_wb);
      end
    end
    if (exp_pcw > 1) begin
      tests_run++;
      if (src_seen !== exp_src) begin
        tests_failed++;
        $display("FAIL pc_src op=%02h: got %0b, required %0b", op, src_seen, exp_src);
      end
    end
    tests_run++;
    if (instret_o !== instret_model()) begin
      tests_failed++;
      $display("FAIL instret op=%02h: got %0d, required %0d", op, instret_o, instret_model());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode_i = 7'h13; funct3_i = 3'd0; zero_i = 1'b0; mem_ready_i = 1'b1;
    tick(); tick(); #1;
    tests_run++;
    if (state_o !== 4'd0 || ctrl !== 15'd0 || instret_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_values: state=%0d ctrl=%h instret=%0d, required 0/0/0", state_o, ctrl, instret_o);
    end
    reset = 1'b0; mem_ready_i = 1'b0; exp_instret = 0;
    #1;
    tests_run++;
    if (state_o !== 4'd0) begin
      tests_failed++;
      $display("FAIL start_cycle: state=%0d, required 0", state_o);
    end
    tick();
    tests_run++;
    if (state_o !== 4'd1) begin
      tests_failed++;
      $display("FAIL start_to_fetch: state=%0d, required 1", state_o);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_addi();
    logic [3:0] seq [6];
    logic [3:0] exp_seq [6];
    int n_rw;
    logic [3:0] rw_state;
    exp_seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd1};
    n_rw = 0; rw_state = 4'hx;
    reset = 1'b1; tick(); reset = 1'b0; exp_instret = 0;
    opcode_i = 7'h13; funct3_i = 3'($urandom_range(0, 7));
    for (int i = 0; i < 6; i++) begin
      mem_ready_i = (i < 5);
      #1;
      seq[i] = state_o;
      if (reg_write_o === 1'b1) begin n_rw++; rw_state = state_o; end
      tick();
    end
    exp_instret = 1;
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (seq[i] !== exp_seq[i]) begin
        tests_failed++;
        $display("FAIL addi_seq[%0d]: state=%0d, required %0d", i, seq[i], exp_seq[i]);
      end
    end
    tests_run++;
    if (n_rw != 1 || rw_state !== 4'd5) begin
      tests_failed++;
      $display("FAIL addi_reg_write: pulses=%0d in state %0d, required 1 in state 5", n_rw, rw_state);
    end
    tests_run++;
    if (instret_o !== instret_model()) begin
      tests_failed++;
      $display("FAIL addi_instret: got %0d, required %0d", instret_o, instret_model());
    end
    $display("[TB] addi sequence %0d %0d %0d %0d %0d %0d", seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]);
  endtask

  task automatic test_load_waits();
    run_instr(7'h03, 3'd2, 1'b0, 2, 3);
  endtask

  task automatic test_branch();
    for (int z = 0; z < 2; z++)
      for (int f = 0; f < 2; f++)
        run_instr(7'h63, 3'(f), 1'(z), $urandom_range(0, 2), 0);
  endtask

  task automatic test_jumps();
    run_instr(7'h6F, 3'd0, 1'b0, 0, 0);
    run_instr(7'h67, 3'd0, 1'b1, 0, 0);
  endtask

  task automatic test_random();
    logic [6:0] ops [8];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
    for (int i = 0; i < 40; i++)
      run_instr(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic test_trap();
    int bad;
    bad = 0;
    opcode_i = 7'h7F; mem_ready_i = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      mem_ready_i = 1'($urandom_range(0, 1));
      #1;
      if (state_o !== 4'd15 || illegal_o !== 1'b1 || (ctrl >> 1) !== 15'd0) bad++;
      tick();
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL trap_hold: %0d bad cycles (state=%0d illegal=%0b ctrl=%h), required 0", bad, state_o, illegal_o, ctrl);
    end
    tests_run++;
    if (instret_o !== instret_model()) begin
      tests_failed++;
      $display("FAIL trap_instret: got %0d, required %0d", instret_o, instret_model());
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (state_o !== 4'd0 || illegal_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL trap_reset: state=%0d illegal=%0b, required 0/0", state_o, illegal_o);
    end
    $display("[TB] trap held 20 cycles, cleared by reset");
    do_reset();
  endtask

  task automatic test_reset_abort();
    run_instr(7'h13, 3'd0, 1'b0, 0, 0);
    opcode_i = 7'h23; mem_ready_i = 1'b1;
    tick(); tick(); tick();
    mem_ready_i = 1'b0;
    tick(); tick();
    #1;
    tests_run++;
    if (state_o !== 4'd9 || mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || instret_o !== instret_model()) begin
      tests_failed++;
      $display("FAIL store_wait: state=%0d req=%0b we=%0b instret=%0d, required 9/1/1/%0d",
               state_o, mem_req_o, mem_we_o, instret_o, instret_model());
    end
    reset = 1'b1; mem_ready_i = 1'b1;
    #1;
    tests_run++;
    if (state_o !== 4'd0 || ctrl !== 15'd0 || instret_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL abort_now: state=%0d ctrl=%h instret=%0d, required 0/0/0", state_o, ctrl, instret_o);
    end
    tick(); #1;
    tests_run++;
    if (state_o !== 4'd0 || ctrl !== 15'd0 || instret_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_wins: state=%0d ctrl=%h instret=%0d, required 0/0/0", state_o, ctrl, instret_o);
    end
    $display("[TB] store aborted by reset during wait");
    reset = 1'b0; exp_instret = 0;
    tick();
    run_instr(7'h37, 3'd0, 1'b0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_waits();
    test_branch();
    test_jumps();
    test_random();
    test_trap();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle control FSM for the RISC-V core: it sequences the shared datapath (PC, IR, register file, one ALU, immediate generator, unified memory port) across several clocks per instruction. It decodes the opcode held in the IR and drives the datapath's select and enable lines. It also runs a request/ready handshake with memory so wait states stall the sequence. It replaces per-instruction parallel hardware with one ALU that is reused for PC+4, address, branch-target and arithmetic work.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode_i  in  7  IR[6:0]
- funct3_i  in  3  IR[14:12]
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  memory completes current request this cycle
- mem_req_o  out  1  memory request active
- mem_we_o  out  1  request is a write
- ir_write_o  out  1  load IR and old_pc
- pc_write_o  out  1  load PC
- pc_src_o  out  1  0 = ALU result, 1 = ALUOut register
- reg_write_o  out  1  register file write
- alu_a_sel_o  out  2  0 = PC, 1 = rs1, 2 = old_pc
- alu_b_sel_o  out  2  0 = rs2, 1 = immediate, 2 = constant 4
- alu_op_o  out  2  0 = add, 1 = sub, 2 = funct-decoded
- wb_sel_o  out  2  0 = ALUOut, 1 = memory data, 2 = PC, 3 = immediate
- illegal_o  out  1  sticky illegal-opcode flag
- state_o  out  4  current state encoding
- instret_o  out  32  retired-instruction count

## Operation
- States and encodings: START 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, ALU_WB 5, MEM_ADDR 6, MEM_READ 7, MEM_WB 8, MEM_WRITE 9, BRANCH 10, JAL 11, JALR 12, LUI 13, TRAP 15.
- Outputs are Moore-decoded from state. The exceptions are ir_write_o and pc_write_o in FETCH, which are gated by mem_ready_i. All unlisted outputs are 0.
- START: all outputs 0. Next state is FETCH.
- FETCH:
  - Drives mem_req_o = 1, a = PC, b = 4, add.
  - While mem_ready_i = 0, stays in FETCH.
  - When mem_ready_i = 1: ir_write_o = 1, pc_write_o = 1, pc_src_o = 0, then go to DECODE.
- DECODE: a = old_pc, b = imm, add (branch/jump target into ALUOut). Dispatch on opcode_i:
  - 0x33 → EXEC_R
  - 0x13 → EXEC_I
  - 0x03 or 0x23 → MEM_ADDR
  - 0x63 → BRANCH
  - 0x6F → JAL
  - 0x67 → JALR
  - 0x37 → LUI
  - anything else → TRAP
- EXEC_R: a = rs1, b = rs2, funct-decoded. Next state ALU_WB.
- EXEC_I: a = rs1, b = imm, funct-decoded. Next state ALU_WB.
- ALU_WB: reg_write_o = 1, wb_sel_o = 0. Retire, then FETCH.
- MEM_ADDR: a = rs1, b = imm, add. Next state is MEM_READ for 0x03, MEM_WRITE for 0x23.
- MEM_READ: mem_req_o = 1. Holds until mem_ready_i = 1, then MEM_WB.
- MEM_WB: reg_write_o = 1, wb_sel_o = 1. Retire, then FETCH.
- MEM_WRITE: mem_req_o = 1, mem_we_o = 1. Holds until mem_ready_i = 1, then retire and go to FETCH.
- BRANCH:
  - a = rs1, b = rs2, sub, pc_src_o = 1.
  - pc_write_o = zero_i XOR funct3_i[0] (beq/bne polarity).
  - Retire, then FETCH.
- JAL: pc_write_o = 1, pc_src_o = 1, reg_write_o = 1, wb_sel_o = 2 (link = already-incremented PC). Retire, then FETCH.
- JALR: a = rs1, b = imm, add, pc_write_o = 1, pc_src_o = 0, reg_write_o = 1, wb_sel_o = 2. The datapath clears bit 0 of the target. Retire, then FETCH.
- LUI: reg_write_o = 1, wb_sel_o = 3. Retire, then FETCH.
- TRAP: illegal_o = 1 and all other outputs 0. Stays in TRAP until reset.
- "Retire" means the final cycle of an instruction, i.e. the transition back to FETCH.

## Timing
- Latency with zero-wait memory, counted as cycles from FETCH to the next FETCH:
  - 3 cycles: branch, JAL, JALR, LUI
  - 4 cycles: R-type, I-type ALU, store
  - 5 cycles: load
- Each wait cycle (mem_ready_i = 0) adds one cycle. Outputs hold stable while waiting.
- mem_req_o is not withdrawn before mem_ready_i = 1. mem_ready_i is ignored in states that have no request.
- Reset values: state START (state_o = 0). Every output is 0, including instret_o and illegal_o.
- Reset asserted mid-instruction, including during a pending memory request, aborts immediately and the instruction does not retire.
- After reset releases: one START cycle, then FETCH.
- Simultaneous reset and mem_ready_i: reset wins.

## Configuration
- PERF_COUNTER_EN defined: instret_o increments by 1 on each retire cycle. It wraps from 0xFFFFFFFF to 0. TRAP does not count.
- PERF_COUNTER_EN undefined: the instret_o port remains and is tied to 0. No counter flops are built.

## Test plan
- Reset, then an addi (0x13) with mem_ready_i held at 1:
  - state sequence 0, 1, 2, 4, 5, 1
  - reg_write_o high exactly one cycle, in state 5
  - instret_o = 1
- Load (0x03) with 2 wait cycles in FETCH and 3 in MEM_READ:
  - 10 cycles from FETCH to the next FETCH
  - mem_req_o held through every wait cycle
  - ir_write_o pulses once
- beq (0x63, funct3 = 0): pc_write_o = 1 in BRANCH when zero_i = 1 and 0 when zero_i = 0. bne (funct3 = 1) gives the inverse.
- JAL then JALR: each spends 3 cycles, asserts pc_write_o and reg_write_o together with wb_sel_o = 2, and drives pc_src_o = 1 for JAL and 0 for JALR.
- Opcode 0x7F: TRAP, illegal_o = 1 and held for 20 cycles with no mem_req_o. Reset clears it to START.
- Assert reset during MEM_WRITE wait, and separately with PERF_COUNTER_EN off:
  - outputs 0 immediately after the reset assertion
  - instret_o unchanged by the aborted store
  - instret_o reads 0 throughout when the macro is off
